// File: rtl/midi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : midi_pkg                                                    |
// | Purpose  : Shared types and constants for the MIDI channel-message     |
// |            decoder: event type encoding, status nibbles, event record. |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package midi_pkg;

  typedef enum logic [2:0] {
    EV_CC7     = 3'd0,
    EV_CC14    = 3'd1,
    EV_PRG     = 3'd2,
    EV_CHPRESS = 3'd3,
    EV_PBEND   = 3'd4
  } ev_type_t;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CTRL     = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHPRESS  = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  localparam logic [7:0]  REALTIME_MIN = 8'hF8;
  localparam logic [13:0] PB_CENTER    = 14'h2000;

  // Channel offset is always held in 4 bits; the top truncates/extends to CH_W.
  typedef struct packed {
    ev_type_t    ev_type;
    logic [3:0]  ch;
    logic [6:0]  num;
    logic [13:0] val;
  } midi_event_t;

  // Program Change and Channel Pressure carry a single data byte.
  function automatic logic is_one_byte_msg(input logic [3:0] st);
    return (st == ST_PROG) || (st == ST_CHPRESS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_event_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : midi_event_fifo                                             |
// | Purpose  : First-word-fall-through event FIFO with level and sticky    |
// |            overflow flag. A write into a full FIFO is accepted only    |
// |            when a pop happens in the same cycle; otherwise dropped.    |
// | Ports    : clk, rst_n (async low), wr_en/wr_data in, rd_valid/rd_ready |
// |            /rd_data out, level, overflow, ovf_clr.                     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module midi_event_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  midi_event_t                wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output midi_event_t                rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  midi_event_t        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   count;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  assign full     = (count == LVL_W'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  assign push     = wr_en & (~full | pop);
  assign drop     = wr_en & full & ~pop;
  assign level    = count;
  // Empty FIFO presents an all-zero record so the outputs read as reset.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_chan_msg_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : midi_chan_msg_decoder                                       |
// | Purpose  : Running-status MIDI parser for CC (7/14-bit), Program       |
// |            Change, Channel Pressure and Pitch Bend in a channel window.|
// |            Decoded events are queued in an event FIFO.                 |
// | Ports    : data_clk, reset_reg_N (async low), byteready/midi_in_data   |
// |            byte input, omni/base_ch window, ev_* FIFO head with        |
// |            ev_valid/ev_ready, fifo_level, overflow, ovf_clr.           |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module midi_chan_msg_decoder
  import midi_pkg::*;
#(
  parameter int CHANNELS   = 16,
  parameter int CH_W       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CC14_EN    = 1
) (
  input  logic                          data_clk,
  input  logic                          reset_reg_N,
  input  logic                          byteready,
  input  logic [7:0]                    midi_in_data,
  input  logic                          omni,
  input  logic [3:0]                    base_ch,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [2:0]                    ev_type,
  output logic [CH_W-1:0]               ev_ch,
  output logic [6:0]                    ev_num,
  output logic [13:0]                   ev_val,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_D1 = 3'd1,
    S_WAIT_D2 = 3'd2,
    S_SKIP_D1 = 3'd3,
    S_SKIP_D2 = 3'd4
  } state_t;

  state_t      state, next_state;
  logic [3:0]  status;
  logic [3:0]  ch_off;
  logic        two_byte;
  logic [6:0]  d1;

  logic        take_status, store_d1, latch_we, emit1, emit2;
  midi_event_t ev1, ev2;

  logic        wr_en, pend_valid;
  midi_event_t wr_ev, pend_ev;
  midi_event_t head;

  logic        lat_hit;
  logic [6:0]  lat_val;

  logic [3:0]  in_off;
  logic        in_accept;
  logic [6:0]  d;

  // Window membership is decided once, at the status byte.
  assign in_off    = midi_in_data[3:0] - base_ch;
  assign in_accept = omni | ({1'b0, in_off} < 5'(CHANNELS));
  assign d         = midi_in_data[6:0];

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= S_IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state  = state;
    take_status = 1'b0;
    store_d1    = 1'b0;
    latch_we    = 1'b0;
    emit1       = 1'b0;
    emit2       = 1'b0;
    ev1         = '0;
    ev2         = '0;
    if (byteready) begin
      if (midi_in_data >= REALTIME_MIN) begin
        // real-time bytes pass through the parser untouched
      end else if (midi_in_data[7:4] == 4'hF) begin
        next_state = S_IDLE;
      end else if (midi_in_data[7]) begin
        take_status = 1'b1;
        next_state  = (in_accept && midi_in_data[7:4] >= ST_CTRL) ? S_WAIT_D1 : S_SKIP_D1;
      end else begin
        case (state)
          S_WAIT_D1: begin
            if (two_byte) begin
              store_d1   = 1'b1;
              next_state = S_WAIT_D2;
            end else begin
              emit1       = 1'b1;
              ev1.ev_type = (status == ST_PROG) ? EV_PRG : EV_CHPRESS;
              ev1.ch      = ch_off;
              ev1.val     = {7'b0, d};
            end
          end
          S_WAIT_D2: begin
            emit1      = 1'b1;
            next_state = S_WAIT_D1;
            ev1.ch     = ch_off;
            if (status == ST_PITCH) begin
              ev1.ev_type = EV_PBEND;
              ev1.val     = {d, d1};
            end else begin
              ev1.ev_type = EV_CC7;
              ev1.num     = d1;
              ev1.val     = {7'b0, d};
              latch_we    = (CC14_EN != 0) && (d1[6:5] == 2'b00);
              // LSB controller 32..63 completes a pair with its MSB (d1-32).
              if ((CC14_EN != 0) && (d1[6:5] == 2'b01) && lat_hit) begin
                emit2       = 1'b1;
                ev2.ev_type = EV_CC14;
                ev2.ch      = ch_off;
                ev2.num     = {2'b00, d1[4:0]};
                ev2.val     = {lat_val, d};
              end
            end
          end
          S_SKIP_D1: if (two_byte) next_state = S_SKIP_D2;
          S_SKIP_D2: next_state = S_SKIP_D1;
          default:   next_state = state;
        endcase
      end
    end
  end

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      status     <= '0;
      ch_off     <= '0;
      two_byte   <= 1'b0;
      d1         <= '0;
      wr_en      <= 1'b0;
      wr_ev      <= '0;
      pend_valid <= 1'b0;
      pend_ev    <= '0;
    end else begin
      if (take_status) begin
        status   <= midi_in_data[7:4];
        ch_off   <= in_off;
        two_byte <= !is_one_byte_msg(midi_in_data[7:4]);
      end
      if (store_d1) d1 <= d;
      // A CC14 pair is staged one cycle behind its CC7; bytes arrive far
      // enough apart that the pending slot is always free again in time.
      if (emit1) begin
        wr_en      <= 1'b1;
        wr_ev      <= ev1;
        pend_valid <= emit2;
        pend_ev    <= ev2;
      end else if (pend_valid) begin
        wr_en      <= 1'b1;
        wr_ev      <= pend_ev;
        pend_valid <= 1'b0;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

  generate
    if (CC14_EN != 0) begin : g_cc14
      // Per-channel MSB latch: {valid, num[4:0], value[6:0]}
      logic [15:0]       msb_vld;
      logic [15:0][4:0]  msb_num;
      logic [15:0][6:0]  msb_val;

      always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
          msb_vld <= '0;
          msb_num <= '0;
          msb_val <= '0;
        end else if (latch_we) begin
          msb_vld[ch_off] <= 1'b1;
          msb_num[ch_off] <= d1[4:0];
          msb_val[ch_off] <= d;
        end
      end

      assign lat_hit = msb_vld[ch_off] && (msb_num[ch_off] == d1[4:0]);
      assign lat_val = msb_val[ch_off];
    end else begin : g_no_cc14
      assign lat_hit = 1'b0;
      assign lat_val = '0;
    end
  endgenerate

  midi_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (data_clk),
    .rst_n    (reset_reg_N),
    .wr_en    (wr_en),
    .wr_data  (wr_ev),
    .rd_valid (ev_valid),
    .rd_ready (ev_ready),
    .rd_data  (head),
    .level    (fifo_level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  assign ev_type = head.ev_type;
  assign ev_ch   = CH_W'(head.ch);
  assign ev_num  = head.num;
  assign ev_val  = head.val;

endmodule
`default_nettype wire
